// File: rtl/gshare_predictor_if.sv
// Fetch/resolve bus between the pipeline and the gshare branch predictor.
// The pipeline drives requests as master; the predictor answers as slave.
interface gshare_predictor_if #(
  parameter int HR_WIDTH  = 8,
  parameter int CTR_WIDTH = 2
);
  logic                 predict_en;
  logic [31:0]          predict_pc;
  logic                 predict_taken;
  logic [CTR_WIDTH-1:0] predict_count;
  logic [HR_WIDTH-1:0]  predict_ghr;

  logic                 resolve_en;
  logic [31:0]          resolve_pc;
  logic [HR_WIDTH-1:0]  resolve_ghr;
  logic                 resolve_taken;
  logic                 resolve_mispredict;

  modport master (
    output predict_en, predict_pc,
    output resolve_en, resolve_pc, resolve_ghr, resolve_taken, resolve_mispredict,
    input  predict_taken, predict_count, predict_ghr
  );

  modport slave (
    input  predict_en, predict_pc,
    input  resolve_en, resolve_pc, resolve_ghr, resolve_taken, resolve_mispredict,
    output predict_taken, predict_count, predict_ghr
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC xor speculative global history indexes a table of
// saturating counters, with snapshot-based history repair and an init sweep.
module gshare_predictor #(
  parameter int INDEX_WIDTH = 10,
  parameter int HR_WIDTH    = 8,
  parameter int CTR_WIDTH   = 2,
  parameter int CTR_INIT    = 1,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PL_stall,
  input  logic                  table_clear,
  output logic                  ready,
  gshare_predictor_if.slave     bp,
  output logic [STAT_WIDTH-1:0] stat_predicts,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr;
  logic [HR_WIDTH-1:0]    ghr;
  logic [CTR_WIDTH-1:0]   pht [ENTRIES];

  logic [INDEX_WIDTH-1:0] pred_idx, res_idx;
  logic [CTR_WIDTH-1:0]   pred_ctr, res_ctr, trained_ctr;
  logic                   running, active;
  logic                   do_repair, do_shift, do_train;

  function automatic logic [INDEX_WIDTH-1:0] hash_index(input logic [31:0] pc,
                                                        input logic [HR_WIDTH-1:0] h);
    logic [INDEX_WIDTH-1:0] ext;
    ext = '0;
    ext[HR_WIDTH-1:0] = h;
    return pc[INDEX_WIDTH+1:2] ^ ext;
  endfunction

  // Shift works for any HR_WIDTH including 1, without a negative slice.
  function automatic logic [HR_WIDTH-1:0] shift_in(input logic [HR_WIDTH-1:0] h,
                                                   input logic b);
    logic [HR_WIDTH-1:0] s;
    s    = h << 1;
    s[0] = b;
    return s;
  endfunction

  assign pred_idx  = hash_index(bp.predict_pc, ghr);
  assign res_idx   = hash_index(bp.resolve_pc, bp.resolve_ghr);
  assign pred_ctr  = pht[pred_idx];
  assign res_ctr   = pht[res_idx];

  assign running   = (state_q == RUN);
  assign active    = running & ~table_clear;
  assign do_repair = active & bp.resolve_en & bp.resolve_mispredict;
  assign do_shift  = active & bp.predict_en & ~PL_stall & ~bp.resolve_mispredict;
  assign do_train  = active & bp.resolve_en;

  always_comb begin
    trained_ctr = res_ctr;
    if (bp.resolve_taken) begin
      if (res_ctr != CTR_MAX) trained_ctr = res_ctr + CTR_WIDTH'(1);
    end else begin
      if (res_ctr != '0) trained_ctr = res_ctr - CTR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    ready            = 1'b0;
    bp.predict_count = '0;
    bp.predict_taken = 1'b0;
    bp.predict_ghr   = '0;
    case (state_q)
      INIT: begin
        if (init_ptr == '1) state_d = RUN;
      end
      RUN: begin
        ready            = 1'b1;
        bp.predict_count = pred_ctr;
        bp.predict_taken = pred_ctr[CTR_WIDTH-1];
        bp.predict_ghr   = ghr;
        if (table_clear) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  // Table contents carry no reset; the sweep is the only way they become defined.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht[init_ptr] <= CTR_WIDTH'(CTR_INIT);
    end else if (do_train) begin
      pht[res_idx] <= trained_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= INIT;
      init_ptr         <= '0;
      ghr              <= '0;
      stat_predicts    <= '0;
      stat_mispredicts <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        init_ptr <= init_ptr + INDEX_WIDTH'(1);
        ghr      <= '0;
      end else if (table_clear) begin
        init_ptr <= '0;
        ghr      <= '0;
      end else if (do_repair) begin
        ghr <= shift_in(bp.resolve_ghr, bp.resolve_taken);
      end else if (do_shift) begin
        ghr <= shift_in(ghr, pred_ctr[CTR_WIDTH-1]);
      end

      if (do_repair && stat_mispredicts != STAT_MAX)
        stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      if (do_shift && stat_predicts != STAT_MAX)
        stat_predicts <= stat_predicts + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized
// traffic checked against a table/arithmetic reference model.
module tb_gshare_predictor;

  localparam int IW       = 8;
  localparam int HW       = 8;
  localparam int CW       = 2;
  localparam int CI       = 1;
  localparam int SW       = 4;
  localparam int ENT      = 256;
  localparam int CTR_TOP  = 3;
  localparam int STAT_TOP = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          PL_stall;
  logic          table_clear;
  logic          ready;
  logic [SW-1:0] stat_predicts;
  logic [SW-1:0] stat_mispredicts;

  gshare_predictor_if #(.HR_WIDTH(HW), .CTR_WIDTH(CW)) bp ();

  gshare_predictor #(
    .INDEX_WIDTH(IW), .HR_WIDTH(HW), .CTR_WIDTH(CW), .CTR_INIT(CI), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .table_clear(table_clear),
    .ready(ready), .bp(bp),
    .stat_predicts(stat_predicts), .stat_mispredicts(stat_mispredicts)
  );

  int checks = 0;
  int errors = 0;

  int m_pht [ENT];
  int m_ghr;
  bit m_ready;
  int m_sweep;
  int m_pred;
  int m_mis;

  function automatic int m_index(input logic [31:0] pc, input int h);
    return int'((pc >> 2) & 32'(ENT - 1)) ^ h;
  endfunction

  function automatic int exp_count();
    return m_ready ? m_pht[m_index(bp.predict_pc, m_ghr)] : 0;
  endfunction

  function automatic int exp_taken();
    return (exp_count() >= 2) ? 1 : 0;
  endfunction

  function automatic int exp_ghr();
    return m_ready ? m_ghr : 0;
  endfunction

  task automatic model_reset();
    m_ready = 0;
    m_sweep = 0;
    m_ghr   = 0;
    m_pred  = 0;
    m_mis   = 0;
  endtask

  task automatic idle_inputs();
    PL_stall              = 1'b0;
    table_clear           = 1'b0;
    bp.predict_en         = 1'b0;
    bp.predict_pc         = '0;
    bp.resolve_en         = 1'b0;
    bp.resolve_pc         = '0;
    bp.resolve_ghr        = '0;
    bp.resolve_taken      = 1'b0;
    bp.resolve_mispredict = 1'b0;
  endtask

  // Advance the model by one cycle from the current inputs, then the clock.
  task automatic tick();
    int pt;
    int ri;
    if (!rst_n) begin
      model_reset();
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == ENT) begin
        for (int i = 0; i < ENT; i++) m_pht[i] = CI;
        m_ready = 1;
      end
    end else if (table_clear) begin
      m_ready = 0;
      m_sweep = 0;
      m_ghr   = 0;
    end else begin
      pt = exp_taken();
      if (bp.resolve_en) begin
        ri = m_index(bp.resolve_pc, int'(bp.resolve_ghr));
        if (bp.resolve_taken) m_pht[ri] = (m_pht[ri] < CTR_TOP) ? m_pht[ri] + 1 : CTR_TOP;
        else                  m_pht[ri] = (m_pht[ri] > 0) ? m_pht[ri] - 1 : 0;
      end
      if (bp.resolve_en && bp.resolve_mispredict) begin
        m_ghr = (int'(bp.resolve_ghr) * 2 + int'(bp.resolve_taken)) % ENT;
        if (m_mis < STAT_TOP) m_mis++;
      end else if (bp.predict_en && !PL_stall && !bp.resolve_mispredict) begin
        m_ghr = (m_ghr * 2 + pt) % ENT;
        if (m_pred < STAT_TOP) m_pred++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", ready);
    end
    checks++;
    if (stat_predicts !== 0 || stat_mispredicts !== 0) begin
      errors++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", stat_predicts, stat_mispredicts);
    end
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 600) begin
      if (n == 100) begin
        checks++;
        if (bp.predict_count !== 0 || bp.predict_taken !== 0 || bp.predict_ghr !== 0) begin
          errors++;
          $display("[TB] FAIL init_outputs: got count=%0d taken=%0b ghr=%0h expected 0/0/0",
                   bp.predict_count, bp.predict_taken, bp.predict_ghr);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (n != ENT) begin
      errors++; $display("[TB] FAIL sweep_length: got %0d cycles expected %0d", n, ENT);
    end
    for (int i = 0; i < ENT; i++) begin
      bp.predict_pc = 32'(i * 4);
      #1;
      checks++;
      if (bp.predict_count !== 2'(CI) || bp.predict_taken !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_entry[%0d]: got count=%0d taken=%0b expected %0d/0",
                 i, bp.predict_count, bp.predict_taken, CI);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    int exp_seq [3] = '{2, 3, 3};
    bp.predict_pc    = 32'h40;
    bp.resolve_en    = 1'b1;
    bp.resolve_pc    = 32'h40;
    bp.resolve_ghr   = '0;
    bp.resolve_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        tick();
        bp.resolve_en = 1'b0;
      end else begin
        tick();
      end
      checks++;
      if (bp.predict_count !== 2'(exp_seq[k])) begin
        errors++; $display("[TB] FAIL saturate_step%0d: got %0d expected %0d", k, bp.predict_count, exp_seq[k]);
      end
    end
    checks++;
    if (bp.predict_taken !== 1'b1) begin
      errors++; $display("[TB] FAIL saturate_taken: got %0b expected 1", bp.predict_taken);
    end
  endtask

  task automatic test_spec_shift();
    logic [31:0] pcs [3] = '{32'h40, 32'h00, 32'h48};
    int          tk  [3] = '{1, 0, 1};
    bp.predict_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bp.predict_pc = pcs[k];
      #1;
      checks++;
      if (bp.predict_taken !== 1'(tk[k])) begin
        errors++; $display("[TB] FAIL shift_taken%0d: got %0b expected %0d", k, bp.predict_taken, tk[k]);
      end
      tick();
    end
    bp.predict_en = 1'b0;
    checks++;
    if (bp.predict_ghr !== 8'h05 || stat_predicts !== 4'd3) begin
      errors++; $display("[TB] FAIL shift_ghr: got ghr=%0h preds=%0d expected 5/3", bp.predict_ghr, stat_predicts);
    end
    PL_stall      = 1'b1;
    bp.predict_en = 1'b1;
    repeat (3) begin
      bp.predict_pc = $urandom;
      tick();
    end
    PL_stall      = 1'b0;
    bp.predict_en = 1'b0;
    checks++;
    if (bp.predict_ghr !== 8'h05 || stat_predicts !== 4'd3) begin
      errors++; $display("[TB] FAIL stall_hold: got ghr=%0h preds=%0d expected 5/3", bp.predict_ghr, stat_predicts);
    end
  endtask

  task automatic test_repair();
    bp.resolve_en         = 1'b1;
    bp.resolve_mispredict = 1'b1;
    bp.resolve_pc         = 32'h0;
    bp.resolve_ghr        = 8'h52;
    bp.resolve_taken      = 1'b1;
    tick();
    checks++;
    if (bp.predict_ghr !== 8'hA5 || stat_mispredicts !== 4'd1) begin
      errors++; $display("[TB] FAIL repair_a5: got ghr=%0h mis=%0d expected a5/1", bp.predict_ghr, stat_mispredicts);
    end
    bp.predict_en  = 1'b1;
    bp.predict_pc  = $urandom;
    bp.resolve_ghr = 8'h3C;
    tick();
    idle_inputs();
    checks++;
    if (bp.predict_ghr !== 8'h79) begin
      errors++; $display("[TB] FAIL repair_priority: got ghr=%0h expected 79", bp.predict_ghr);
    end
    checks++;
    if (stat_mispredicts !== 4'd2 || stat_predicts !== 4'd3) begin
      errors++; $display("[TB] FAIL repair_stats: got mis=%0d preds=%0d expected 2/3", stat_mispredicts, stat_predicts);
    end
  endtask

  task automatic test_same_index();
    bp.predict_pc    = 32'h164;
    bp.resolve_en    = 1'b1;
    bp.resolve_pc    = 32'h80;
    bp.resolve_ghr   = '0;
    bp.resolve_taken = 1'b1;
    #1;
    checks++;
    if (bp.predict_count !== 2'd1) begin
      errors++; $display("[TB] FAIL same_index_pre: got %0d expected 1", bp.predict_count);
    end
    tick();
    bp.resolve_en = 1'b0;
    #1;
    checks++;
    if (bp.predict_count !== 2'd2) begin
      errors++; $display("[TB] FAIL same_index_post: got %0d expected 2", bp.predict_count);
    end
  endtask

  task automatic test_clear();
    int n;
    bp.predict_en = 1'b1;
    repeat (2) begin
      bp.predict_pc = $urandom;
      tick();
    end
    bp.predict_en = 1'b0;
    table_clear   = 1'b1;
    tick();
    table_clear = 1'b0;
    checks++;
    if (ready !== 1'b0 || bp.predict_ghr !== 0) begin
      errors++; $display("[TB] FAIL clear_enter: got ready=%0b ghr=%0h expected 0/0", ready, bp.predict_ghr);
    end
    n = 0;
    while (ready !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n != ENT) begin
      errors++; $display("[TB] FAIL clear_sweep: got %0d cycles expected %0d", n, ENT);
    end
    checks++;
    if (stat_predicts !== 4'd5 || stat_mispredicts !== 4'd2) begin
      errors++; $display("[TB] FAIL clear_stats: got preds=%0d mis=%0d expected 5/2", stat_predicts, stat_mispredicts);
    end
    table_clear = 1'b1;
    tick();
    table_clear = 1'b0;
    repeat (50) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0 || stat_predicts !== 0 || stat_mispredicts !== 0) begin
      errors++; $display("[TB] FAIL midsweep_reset: got ready=%0b preds=%0d mis=%0d expected 0/0/0",
                         ready, stat_predicts, stat_mispredicts);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n != ENT) begin
      errors++; $display("[TB] FAIL restart_sweep: got %0d cycles expected %0d", n, ENT);
    end
    bp.predict_pc = 32'h40;
    #1;
    checks++;
    if (bp.predict_count !== 2'(CI)) begin
      errors++; $display("[TB] FAIL restart_entry: got %0d expected %0d", bp.predict_count, CI);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      PL_stall              = ($urandom_range(0, 3) == 0);
      table_clear           = ($urandom_range(0, 399) == 0);
      bp.predict_en         = $urandom_range(0, 1);
      bp.predict_pc         = $urandom;
      bp.resolve_en         = $urandom_range(0, 1);
      bp.resolve_pc         = $urandom;
      bp.resolve_ghr        = 8'($urandom);
      bp.resolve_taken      = $urandom_range(0, 1);
      bp.resolve_mispredict = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (ready !== 1'(m_ready) || int'(bp.predict_count) != exp_count() ||
          int'(bp.predict_taken) != exp_taken() || int'(bp.predict_ghr) != exp_ghr()) begin
        errors++;
        $display("[TB] FAIL random_pred@%0d: got ready=%0b count=%0d taken=%0b ghr=%0h expected %0b/%0d/%0d/%0h",
                 c, ready, bp.predict_count, bp.predict_taken, bp.predict_ghr,
                 m_ready, exp_count(), exp_taken(), exp_ghr());
      end
      checks++;
      if (int'(stat_predicts) != m_pred || int'(stat_mispredicts) != m_mis) begin
        errors++;
        $display("[TB] FAIL random_stats@%0d: got preds=%0d mis=%0d expected %0d/%0d",
                 c, stat_predicts, stat_mispredicts, m_pred, m_mis);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_saturate();
    test_spec_shift();
    test_repair();
    test_same_index();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
